// File: rtl/instruction_fetch_sequencer_pkg.sv
// Shared definitions for the instruction fetch sequencer.
//  - Default ROM address / instruction widths.
//  - Opcode encodings (opcode field = instr[INSTR_W-1:ADDR_W]).
//  - FSM state encodings S_BOOT / S_RUN / S_HALT.
package instruction_fetch_sequencer_pkg;

  localparam int DEF_ADDR_W  = 10;
  localparam int DEF_INSTR_W = 16;
  localparam int OPC_W       = DEF_INSTR_W - DEF_ADDR_W;

  localparam logic [OPC_W-1:0] OP_NOP  = 6'h00;
  localparam logic [OPC_W-1:0] OP_LDA  = 6'h01;
  localparam logic [OPC_W-1:0] OP_LDB  = 6'h02;
  localparam logic [OPC_W-1:0] OP_ADDA = 6'h03;
  localparam logic [OPC_W-1:0] OP_JMP  = 6'h04;

  localparam logic [1:0] S_BOOT = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_HALT = 2'd2;

endpackage

// File: rtl/instruction_fetch_sequencer_if.sv
// Bus bundle between the fetch sequencer and its surroundings
// (instruction ROM, hazard unit, EX stage, decode, control).
//  master : the sequencer (drives ROM address, IF/ID outputs, status, counters)
//  slave  : the environment (drives ROM data, stall, branch, halt/resume)
interface instruction_fetch_sequencer_if #(
  parameter int ADDR_W  = 10,
  parameter int INSTR_W = 16,
  parameter int CNT_W   = 16
);
  logic [ADDR_W-1:0]  oRomAddress;
  logic [INSTR_W-1:0] iRomInstruction;
  logic               iStall;
  logic               iBranchTaken;
  logic [ADDR_W-1:0]  iBranchTarget;
  logic               iHalt;
  logic               iResume;
  logic [INSTR_W-1:0] oInstruction;
  logic [ADDR_W-1:0]  oPC_ID;
  logic               oValid_ID;
  logic               oSquashID;
  logic               oHalted;
  logic [CNT_W-1:0]   oBubbleCount;
  logic [CNT_W-1:0]   oFetchCount;

  modport master (
    output oRomAddress, oInstruction, oPC_ID, oValid_ID, oSquashID,
           oHalted, oBubbleCount, oFetchCount,
    input  iRomInstruction, iStall, iBranchTaken, iBranchTarget, iHalt, iResume
  );

  modport slave (
    input  oRomAddress, oInstruction, oPC_ID, oValid_ID, oSquashID,
           oHalted, oBubbleCount, oFetchCount,
    output iRomInstruction, iStall, iBranchTaken, iBranchTarget, iHalt, iResume
  );
endinterface

// File: rtl/instruction_fetch_sequencer_fetch_pc_reg.sv
// Program counter register.
//  clk, rst_n : clock, asynchronous active-low reset (loads RESET_VECTOR)
//  load_en    : load load_val (takes priority over inc_en)
//  load_val   : redirect target
//  inc_en     : advance PC by one, wrapping modulo 2^ADDR_W
//  pc         : current PC
module fetch_pc_reg #(
  parameter int ADDR_W       = 10,
  parameter int RESET_VECTOR = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_val,
  input  logic              inc_en,
  output logic [ADDR_W-1:0] pc
);

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_d;

  always_comb begin
    pc_d = pc_q;
    if (load_en)     pc_d = load_val;
    else if (inc_en) pc_d = pc_q + {{(ADDR_W-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc_q <= ADDR_W'(RESET_VECTOR);
    else        pc_q <= pc_d;
  end

  assign pc = pc_q;

endmodule

// File: rtl/instruction_fetch_sequencer.sv
// Instruction fetch sequencer: owns the PC and the IF/ID register in front
// of a combinational instruction ROM, and sequences sequential fetch, stalls,
// JMP redirects (resolved in ID), taken-branch redirects (from EX) and halt.
//  Clock : rising-edge clock
//  Reset : asynchronous active-low reset
//  bus   : master side of the fetch bus (ROM address/data, stall, branch,
//          halt/resume, IF/ID outputs, squash, halted, performance counters)
module instruction_fetch_sequencer
  import instruction_fetch_sequencer_pkg::*;
#(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int INSTR_W      = DEF_INSTR_W,
  parameter int RESET_VECTOR = 0,
  parameter int CNT_W        = 16
) (
  input  logic                         Clock,
  input  logic                         Reset,
  instruction_fetch_sequencer_if.master bus
);

  localparam int OP_W = INSTR_W - ADDR_W;
  localparam logic [INSTR_W-1:0] NOP_INSTR = {OP_W'(OP_NOP), {ADDR_W{1'b0}}};

  logic [1:0]         state_q,  state_d;
  logic [INSTR_W-1:0] instr_q,  instr_d;
  logic [ADDR_W-1:0]  pc_id_q,  pc_id_d;
  logic               valid_q,  valid_d;
  logic [CNT_W-1:0]   bubble_q, bubble_d;
  logic [CNT_W-1:0]   fetch_q,  fetch_d;

  logic               pc_load;
  logic [ADDR_W-1:0]  pc_load_val;
  logic               pc_inc;
  logic [ADDR_W-1:0]  pc;
  logic               jmp_in_id;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == {CNT_W{1'b1}}) ? c : c + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  fetch_pc_reg #(
    .ADDR_W       (ADDR_W),
    .RESET_VECTOR (RESET_VECTOR)
  ) u_pc (
    .clk      (Clock),
    .rst_n    (Reset),
    .load_en  (pc_load),
    .load_val (pc_load_val),
    .inc_en   (pc_inc),
    .pc       (pc)
  );

  assign jmp_in_id = valid_q && (instr_q[INSTR_W-1:ADDR_W] == OP_W'(OP_JMP));

  always_comb begin
    state_d     = state_q;
    instr_d     = instr_q;
    pc_id_d     = pc_id_q;
    valid_d     = valid_q;
    bubble_d    = bubble_q;
    fetch_d     = fetch_q;
    pc_load     = 1'b0;
    pc_load_val = pc;
    pc_inc      = 1'b0;

    case (state_q)
      // ROM output is not trusted on the first cycle out of reset.
      S_BOOT: state_d = S_RUN;

      S_RUN: begin
        // Halt request still lets this edge do its normal run update.
        if (bus.iHalt) state_d = S_HALT;
        if (!valid_q)  bubble_d = sat_inc(bubble_q);

        if (bus.iBranchTaken) begin
          // EX redirect wins over stall and over a JMP sitting in ID.
          pc_load     = 1'b1;
          pc_load_val = bus.iBranchTarget;
          instr_d     = NOP_INSTR;
          valid_d     = 1'b0;
        end else if (jmp_in_id && !bus.iStall) begin
          // The slot fetched behind the JMP is wrong-path: one bubble.
          pc_load     = 1'b1;
          pc_load_val = instr_q[ADDR_W-1:0];
          instr_d     = NOP_INSTR;
          valid_d     = 1'b0;
        end else if (!bus.iStall) begin
          instr_d = bus.iRomInstruction;
          pc_id_d = pc;
          valid_d = 1'b1;
          pc_inc  = 1'b1;
          fetch_d = sat_inc(fetch_q);
        end
      end

      S_HALT: begin
        // Resume loses to a simultaneous halt request.
        if (bus.iResume && !bus.iHalt) state_d = S_RUN;
        instr_d = NOP_INSTR;
        valid_d = 1'b0;
      end

      default: state_d = S_BOOT;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q  <= S_BOOT;
      instr_q  <= NOP_INSTR;
      pc_id_q  <= '0;
      valid_q  <= 1'b0;
      bubble_q <= '0;
      fetch_q  <= '0;
    end else begin
      state_q  <= state_d;
      instr_q  <= instr_d;
      pc_id_q  <= pc_id_d;
      valid_q  <= valid_d;
      bubble_q <= bubble_d;
      fetch_q  <= fetch_d;
    end
  end

  assign bus.oRomAddress  = pc;
  assign bus.oInstruction = instr_q;
  assign bus.oPC_ID       = pc_id_q;
  assign bus.oValid_ID    = valid_q;
  assign bus.oSquashID    = bus.iBranchTaken;
  assign bus.oHalted      = (state_q == S_HALT);
  assign bus.oBubbleCount = bubble_q;
  assign bus.oFetchCount  = fetch_q;

endmodule
